// File: rtl/or2t_pulse_scheduler.sv
// Sequencer for one clocked OR2T cell: generates the toggle-encoded cell clock, arbitrates
// requesters onto the a/b inputs outside the setup/hold window, and predicts the delayed q.
module or2t_pulse_scheduler #(
    parameter int NREQ         = 4,
    parameter int PERIOD_TICKS = 16,
    parameter int SETUP_TICKS  = 2,
    parameter int HOLD_TICKS   = 3,
    parameter int DELAY_TICKS  = 6
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            run,
    input  logic [NREQ-1:0]                 req,
    input  logic [NREQ-1:0]                 sel,
    output logic [NREQ-1:0]                 gnt,
    output logic                            a_tgl,
    output logic                            b_tgl,
    output logic                            cell_clk_tgl,
    output logic                            q_exp,
    output logic                            q_evt,
    output logic [$clog2(PERIOD_TICKS)-1:0] phase,
    output logic [7:0]                      absorbed_cnt
);

    localparam int PW          = $clog2(PERIOD_TICKS);
    localparam int QW          = $clog2(DELAY_TICKS + 1);
    localparam int SETUP_START = PERIOD_TICKS - SETUP_TICKS;

    if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
        $error("or2t_pulse_scheduler: NREQ must be in 2..8");
    end
    if (HOLD_TICKS < 1 || SETUP_TICKS < 0 || SETUP_TICKS + HOLD_TICKS >= PERIOD_TICKS) begin : g_bad_window
        $error("or2t_pulse_scheduler: need HOLD_TICKS>=1 and SETUP_TICKS+HOLD_TICKS<PERIOD_TICKS");
    end
    if (DELAY_TICKS < 1 || DELAY_TICKS > PERIOD_TICKS - 1) begin : g_bad_delay
        $error("or2t_pulse_scheduler: DELAY_TICKS must be in 1..PERIOD_TICKS-1");
    end

    logic [PW-1:0]   phase_q, phase_d;
    logic            clk_q, clk_d;
    logic            a_q, a_d;
    logic            b_q, b_d;
    logic            shadow_q, shadow_d;
    logic [7:0]      abs_q, abs_d;
    logic [QW-1:0]   qcnt_q, qcnt_d;
    logic            q_q, q_d;
    logic            qevt_q, qevt_d;
    logic [NREQ-1:0] rr_mask_q, rr_mask_d;

    logic            blackout;
    logic [NREQ-1:0] upper, pick, gnt_c;
    logic            xfer, xfer_b;

    assign blackout = ((SETUP_TICKS > 0) && (int'(phase_q) >= SETUP_START)) ||
                      (int'(phase_q) < HOLD_TICKS);

    // Round-robin pointer kept as a mask of requesters at or above it; an empty mask means pointer 0.
    always_comb begin
        gnt_c = '0;
        upper = req & rr_mask_q;
        pick  = (|upper) ? upper : req;
        if (!rst && run && !blackout) begin
            gnt_c = pick & (~pick + 1'b1);
        end
    end

    assign xfer   = |(req & gnt_c);
    assign xfer_b = |(sel & gnt_c);

    always_comb begin
        phase_d   = phase_q;
        clk_d     = clk_q;
        a_d       = a_q;
        b_d       = b_q;
        shadow_d  = shadow_q;
        abs_d     = abs_q;
        qcnt_d    = qcnt_q;
        q_d       = q_q;
        qevt_d    = 1'b0;
        rr_mask_d = rr_mask_q;

        // The q-delay runs regardless of run, so a loaded toggle always lands.
        if (qcnt_q != '0) begin
            qcnt_d = qcnt_q - 1'b1;
            if (qcnt_q == QW'(1)) begin
                q_d    = ~q_q;
                qevt_d = 1'b1;
            end
        end

        if (xfer) begin
            if (xfer_b) begin
                b_d = ~b_q;
            end else begin
                a_d = ~a_q;
            end
            if (shadow_q && abs_q != 8'hFF) begin
                abs_d = abs_q + 8'd1;
            end
            shadow_d  = 1'b1;
            rr_mask_d = ~(gnt_c | (gnt_c - 1'b1));
        end

        // Phase 0 is always inside the blackout, so this never collides with a transfer.
        if (run) begin
            phase_d = (phase_q == PW'(PERIOD_TICKS - 1)) ? '0 : phase_q + PW'(1);
            if (phase_q == '0) begin
                clk_d = ~clk_q;
                if (shadow_q) begin
                    qcnt_d   = QW'(DELAY_TICKS);
                    shadow_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q   <= '0;
            clk_q     <= 1'b0;
            a_q       <= 1'b0;
            b_q       <= 1'b0;
            shadow_q  <= 1'b0;
            abs_q     <= 8'd0;
            qcnt_q    <= '0;
            q_q       <= 1'b0;
            qevt_q    <= 1'b0;
            rr_mask_q <= '1;
        end else begin
            phase_q   <= phase_d;
            clk_q     <= clk_d;
            a_q       <= a_d;
            b_q       <= b_d;
            shadow_q  <= shadow_d;
            abs_q     <= abs_d;
            qcnt_q    <= qcnt_d;
            q_q       <= q_d;
            qevt_q    <= qevt_d;
            rr_mask_q <= rr_mask_d;
        end
    end

    assign gnt          = gnt_c;
    assign a_tgl        = a_q;
    assign b_tgl        = b_q;
    assign cell_clk_tgl = clk_q;
    assign q_exp        = q_q;
    assign q_evt        = qevt_q;
    assign phase        = phase_q;
    assign absorbed_cnt = abs_q;

endmodule

// File: tb/tb_or2t_pulse_scheduler.sv
// Bench for or2t_pulse_scheduler: directed and random request traffic against a cycle-level
// reference model; expectations are queued and checked by an independent monitor.
module tb_or2t_pulse_scheduler;

    localparam int NREQ   = 4;
    localparam int PERIOD = 16;
    localparam int SETUP  = 2;
    localparam int HOLD   = 3;
    localparam int DELAY  = 6;
    localparam int PW     = $clog2(PERIOD);

    logic            clk;
    logic            rst;
    logic            run;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] sel;
    logic [NREQ-1:0] gnt;
    logic            a_tgl, b_tgl, cell_clk_tgl, q_exp, q_evt;
    logic [PW-1:0]   phase;
    logic [7:0]      absorbed_cnt;

    or2t_pulse_scheduler #(
        .NREQ(NREQ), .PERIOD_TICKS(PERIOD), .SETUP_TICKS(SETUP),
        .HOLD_TICKS(HOLD), .DELAY_TICKS(DELAY)
    ) dut (
        .clk(clk), .rst(rst), .run(run), .req(req), .sel(sel), .gnt(gnt),
        .a_tgl(a_tgl), .b_tgl(b_tgl), .cell_clk_tgl(cell_clk_tgl),
        .q_exp(q_exp), .q_evt(q_evt), .phase(phase), .absorbed_cnt(absorbed_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string nm, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s cyc=%0d actual=%0d expected=%0d", nm, cyc, act, exp);
        end
    endtask

    typedef struct {
        int cyc;
        int gnt;
        int phase;
        int absn;
        bit a, b, clk, q, qevt;
    } snap_t;

    snap_t snq[$];   // expected per-cycle view, one entry per cycle
    int    evq[$];   // cycles in which a q toggle must appear

    // Reference model state
    int  m_phase = 0, m_ptr = 0, m_abs = 0;
    bit  m_shadow = 0, m_a = 0, m_b = 0, m_clk = 0, m_q = 0;
    int  m_due[$];
    int  last_w;

    logic [NREQ-1:0] hreq = '0;
    logic [NREQ-1:0] hsel = '0;

    task automatic step(input bit r, input bit rn, input logic [NREQ-1:0] rq, input logic [NREQ-1:0] sl);
        snap_t s;
        int w, idx;
        bit ev;
        logic [NREQ-1:0] t;
        rst = r; run = rn; req = rq; sel = sl;
        ev = 0;
        if (m_due.size() > 0 && m_due[0] == cyc) begin
            void'(m_due.pop_front());
            m_q = !m_q;
            ev = 1;
        end
        w = -1;
        if (!r && rn && !(m_phase >= PERIOD - SETUP || m_phase < HOLD)) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = (m_ptr + k) % NREQ;
                t = rq >> idx;
                if (w < 0 && t[0]) w = idx;
            end
        end
        s.cyc = cyc; s.gnt = (w < 0) ? 0 : (1 << w); s.phase = m_phase; s.absn = m_abs;
        s.a = m_a; s.b = m_b; s.clk = m_clk; s.q = m_q; s.qevt = ev;
        snq.push_back(s);
        last_w = w;
        if (r) begin
            m_phase = 0; m_ptr = 0; m_abs = 0; m_shadow = 0;
            m_a = 0; m_b = 0; m_clk = 0; m_q = 0;
            m_due.delete();
            while (evq.size() > 0 && evq[$] > cyc) void'(evq.pop_back());
        end else begin
            if (w >= 0) begin
                t = sl >> w;
                if (t[0]) m_b = !m_b; else m_a = !m_a;
                if (m_shadow && m_abs < 255) m_abs++;
                m_shadow = 1;
                m_ptr = (w + 1) % NREQ;
            end
            if (rn) begin
                if (m_phase == 0) begin
                    m_clk = !m_clk;
                    if (m_shadow) begin
                        m_due.push_back(cyc + 1 + DELAY);
                        evq.push_back(cyc + 1 + DELAY);
                        m_shadow = 0;
                    end
                end
                m_phase = (m_phase + 1) % PERIOD;
            end
        end
    endtask

    // Requesters hold their request until granted.
    task automatic drive(input bit r, input bit rn);
        @(posedge clk);
        #1;
        step(r, rn, hreq, hsel);
        if (last_w >= 0) hreq &= ~(NREQ'(1) << last_w);
        if (r) hreq = '0;
    endtask

    task automatic run_to_phase(input int ph);
        for (int i = 0; i < PERIOD + 1 && m_phase != ph; i++) drive(0, 1);
    endtask

    // Monitor
    initial begin : monitor
        snap_t s;
        bit prev_q, rst_prev, qchg;
        int due;
        prev_q = 0; rst_prev = 0;
        forever begin
            @(negedge clk);
            if (rst_prev) prev_q = 0;
            qchg = (q_exp !== prev_q);
            if (qchg || q_evt) begin
                if (evq.size() == 0) begin
                    chk("q_evt_unexpected", 1, 0);
                end else begin
                    due = evq.pop_front();
                    chk("q_evt_cycle", cyc, due);
                    chk("q_evt_strobe", int'(q_evt), 1);
                    chk("q_exp_changed", int'(qchg), 1);
                end
            end
            prev_q = q_exp;
            rst_prev = rst;
            if (snq.size() > 0) begin
                s = snq.pop_front();
                chk("snap_cycle", cyc, s.cyc);
                chk("gnt", int'(gnt), s.gnt);
                chk("phase", int'(phase), s.phase);
                chk("absorbed_cnt", int'(absorbed_cnt), s.absn);
                chk("a_tgl", int'(a_tgl), int'(s.a));
                chk("b_tgl", int'(b_tgl), int'(s.b));
                chk("cell_clk_tgl", int'(cell_clk_tgl), int'(s.clk));
                chk("q_exp", int'(q_exp), int'(s.q));
                chk("q_evt", int'(q_evt), int'(s.qevt));
            end
        end
    end

    initial begin : stimulus
        rst = 1'b1; run = 1'b0; req = '0; sel = '0;
        repeat (3) drive(1, 0);

        // Idle clock generation
        repeat (40) drive(0, 1);

        // Single request on a
        run_to_phase(5);
        hreq[0] = 1'b1; hsel[0] = 1'b0;
        repeat (40) drive(0, 1);

        // Request arriving inside the setup blackout, targeting b
        run_to_phase(14);
        hreq[2] = 1'b1; hsel[2] = 1'b1;
        repeat (40) drive(0, 1);

        // All requesters at once from pointer 0
        drive(1, 0);
        run_to_phase(4);
        hreq = '1; hsel = 4'b1010;
        repeat (40) drive(0, 1);
        @(negedge clk);
        chk("absorbed_after_all4", int'(absorbed_cnt), 3);

        // Reset two cycles after a loaded cell clock edge
        run_to_phase(5);
        hreq[3] = 1'b1; hsel[3] = 1'b0;
        run_to_phase(0);
        drive(0, 1);
        drive(0, 1);
        drive(1, 1);
        repeat (20) drive(0, 1);

        // run dropped at phase 9 with a held request
        run_to_phase(9);
        hreq[1] = 1'b1; hsel[1] = 1'b1;
        repeat (10) drive(0, 0);
        repeat (40) drive(0, 1);

        // Continuous requests drive absorbed_cnt into saturation
        for (int i = 0; i < 500; i++) begin
            hreq = '1; hsel = NREQ'($urandom);
            drive(0, 1);
        end
        @(negedge clk);
        chk("absorbed_saturated", int'(absorbed_cnt), 255);

        // Random traffic
        drive(1, 0);
        for (int i = 0; i < 1500; i++) begin
            for (int j = 0; j < NREQ; j++)
                if (!hreq[j] && $urandom_range(0, 9) < 3) hreq[j] = 1'b1;
            hsel = NREQ'($urandom);
            drive($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0);
        end

        // Flush outstanding q toggles
        hreq = '0;
        repeat (30) drive(0, 1);
        @(negedge clk);
        #1;
        chk("evq_drained", evq.size(), 0);
        chk("snq_drained", snq.size(), 0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/or2t_pulse_scheduler.md
Name: or2t_pulse_scheduler

Overview:
- Synchronous sequencer that drives one clocked OR2T cell model. In this codebase an SFQ pulse is encoded as a level toggle (either edge counts).
- Generates the cell's periodic clock pulse and arbitrates NREQ requesters that want to inject pulses on the cell's a or b input.
- Blocks injections inside the setup/hold blackout around each cell clock.
- Keeps a shadow of the cell state and produces the expected q, delayed by the cell's clk-to-q latency, for the checkers.

Parameters:
NREQ, 4, number of requesters (2..8)
PERIOD_TICKS, 16, cell clock period in clk cycles
SETUP_TICKS, 2, minimum cycles between a data toggle and the next cell clock toggle
HOLD_TICKS, 3, minimum cycles after a cell clock toggle before the next data toggle (>=1)
DELAY_TICKS, 6, cell clk-to-q delay in cycles (1..PERIOD_TICKS-1)
- Legality: SETUP_TICKS+HOLD_TICKS < PERIOD_TICKS. Any violation is a static elaboration error.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
run  in  1  enable for clock generation and grants
req  in  NREQ  per-requester pulse request, held until granted
sel  in  NREQ  per-requester target input: 0=a, 1=b
gnt  out  NREQ  one-hot grant, combinational; transfer occurs when req[i]&gnt[i]
a_tgl  out  1  cell input a, toggle-encoded pulse
b_tgl  out  1  cell input b, toggle-encoded pulse
cell_clk_tgl  out  1  cell clock, toggle-encoded pulse
q_exp  out  1  expected cell q, toggle-encoded
q_evt  out  1  one-cycle strobe, high in the cycle q_exp changes
phase  out  clog2(PERIOD_TICKS)  current phase counter
absorbed_cnt  out  8  saturating count of pulses merged into an already-set state

Behaviour:
- Reset: a_tgl, b_tgl, cell_clk_tgl, q_exp, q_evt = 0; phase = 0; shadow state = 0; round-robin pointer = 0; absorbed_cnt = 0; pending q-delay cleared; gnt = 0 while rst is high.
- Phase: on each cycle with run=1:
  - phase advances, wrapping PERIOD_TICKS-1 -> 0;
  - if phase==0 in that cycle, cell_clk_tgl flips at the clock edge.
  - The first cell clock toggle therefore lands at the end of the first run cycle after reset.
- run=0: phase holds, no cell clock toggles, gnt=0. Any pending q-delay keeps counting and still fires.
- Blackout: phase >= PERIOD_TICKS-SETUP_TICKS, or phase < HOLD_TICKS (includes phase 0). During blackout gnt=0.
- Arbitration, outside blackout with run=1:
  - exactly one grant to the first asserted req at or after the pointer (round-robin);
  - the pointer moves to winner+1 mod NREQ;
  - at most one grant per cycle;
  - req without a grant holds with no penalty.
- On transfer: a_tgl flips if sel[i]=0, else b_tgl flips, at the same edge.
  - Shadow state 0 -> 1.
  - If the shadow state was already 1, absorbed_cnt increments, saturating at 255.
- Cell clock edge (phase 0, run=1):
  - shadow state 1: the q-delay counter loads DELAY_TICKS and shadow state clears;
  - shadow state 0: no effect.
  - Grants cannot coincide with this edge (blackout).
- q-delay: the counter decrements every cycle. When it expires, q_exp flips and q_evt=1 for that cycle.
  - Expiry falls exactly DELAY_TICKS cycles after the cell_clk_tgl flip that loaded it.
  - At most one delay is ever pending (DELAY_TICKS < PERIOD_TICKS).
- rst mid-operation: a pending q toggle is discarded and all state returns to reset values. No q_evt is produced.
- sel is sampled only in the transfer cycle. req/sel changes without a grant have no effect.

Test Plan:
- Defaults, rst then run=1 with no req -> cell_clk_tgl flips at cycles 1, 17, 33; a_tgl, b_tgl, q_exp stay 0; absorbed_cnt=0.
- req[0]=1, sel[0]=0 asserted at phase 5 -> gnt=0001 that cycle; a_tgl=1 next edge; cell_clk_tgl flips at the following phase 0; q_exp=1 with a q_evt pulse 6 cycles later.
- req[2]=1 first asserted at phase 14 -> gnt withheld for phases 14, 15, 0, 1, 2; granted at phase 3; b_tgl flips if sel[2]=1.
- All four req asserted at phase 4, pointer=0 -> grants 0, 1, 2, 3 at phases 4, 5, 6, 7; absorbed_cnt=3; exactly one q_exp toggle after the next cell clock.
- rst asserted 2 cycles after a loaded cell clock edge -> q_exp=0, no q_evt afterwards, phase=0, absorbed_cnt=0.
- run dropped at phase 9 for 10 cycles with req[1] held -> phase frozen at 9, gnt=0; on run=1 grant at phase 9; cell clock spacing resumes at 16 run-cycles.
